// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller button/control bundle.
// master: the side that owns the buttons and consumes go/cnt_reset/running/lap_hold.
// slave : the stopwatch controller itself.
interface stopwatch_ctrl_if;
  logic start_stop;  // raw start/stop pushbutton level, active-high
  logic clear;       // raw clear pushbutton level, active-high
  logic go;          // one-cycle tenth-second enable to the counter block
  logic cnt_reset;   // active-high clear to the counter block
  logic running;     // high while the FSM is in RUN
  logic lap_hold;    // display-freeze request

  modport master (
    output start_stop, clear,
    input  go, cnt_reset, running, lap_hold
  );

  modport slave (
    input  start_stop, clear,
    output go, cnt_reset, running, lap_hold
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button synchronizers and press detection, IDLE/RUN/PAUSED
// FSM, tenth-second prescaler producing the counter's go pulse.
// Optional lap/display-freeze behaviour is enabled by defining STOPWATCH_LAP_EN;
// without it lap_hold is tied low and clear in RUN is ignored.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 5000000  // clk cycles per tenth-second, 2..2^24
) (
  input  logic            clk,
  input  logic            reset,   // synchronous, active-high
  stopwatch_ctrl_if.slave sw
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_RUN    = 2'b01;
  localparam logic [1:0] S_PAUSED = 2'b10;

  // Button synchronizers: meta -> sync -> prev. A press is sync=1, prev=0,
  // so a held button yields exactly one event.
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic cl_meta_q, cl_sync_q, cl_prev_q;
  logic ss_ev, cl_ev;

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;

  // Two-flop synchronizers plus previous-value flops for both buttons
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_meta_q <= 1'b0;
      ss_sync_q <= 1'b0;
      ss_prev_q <= 1'b0;
      cl_meta_q <= 1'b0;
      cl_sync_q <= 1'b0;
      cl_prev_q <= 1'b0;
    end else begin
      ss_meta_q <= sw.start_stop;
      ss_sync_q <= ss_meta_q;
      ss_prev_q <= ss_sync_q;
      cl_meta_q <= sw.clear;
      cl_sync_q <= cl_meta_q;
      cl_prev_q <= cl_sync_q;
    end
  end

  // start_stop wins a same-cycle collision; the clear press is simply dropped.
  assign ss_ev = ss_sync_q & ~ss_prev_q;
  assign cl_ev = cl_sync_q & ~cl_prev_q & ~ss_ev;

`ifdef STOPWATCH_LAP_EN
  logic lap_q, lap_d;

  // Next state and lap-hold toggling
  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    case (state_q)
      S_IDLE: begin
        if (ss_ev) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_ev)      state_d = S_PAUSED;
        else if (cl_ev) lap_d   = ~lap_q;
      end
      S_PAUSED: begin
        if (ss_ev) begin
          state_d = S_RUN;
        end else if (cl_ev) begin
          // First clear releases a frozen display; the next one clears the watch.
          if (lap_q) lap_d   = 1'b0;
          else       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) lap_d = 1'b0;
  end

  // Lap-hold register
  always_ff @(posedge clk) begin
    if (reset) lap_q <= 1'b0;
    else       lap_q <= lap_d;
  end

  assign sw.lap_hold = lap_q;
`else
  // Next state; clear only matters in PAUSED
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ss_ev) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_ev) state_d = S_PAUSED;
      end
      S_PAUSED: begin
        if (ss_ev)      state_d = S_RUN;
        else if (cl_ev) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sw.lap_hold = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Prescaler next value: counts only in RUN, holds in PAUSED so a resume keeps
  // the partial tenth, and is zero whenever the watch is (or is about to be) idle.
  always_comb begin
    presc_d = '0;
    case (state_q)
      S_RUN:    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + 1'b1;
      S_PAUSED: presc_d = (state_d == S_IDLE) ? '0 : presc_q;
      default:  presc_d = '0;
    endcase
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (reset) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // Outputs decode registered state only; reset suppresses a go in its own cycle
  // so a mid-RUN abort never emits one more tick.
  assign sw.go        = (state_q == S_RUN) && (presc_q == PRE_LAST) && !reset;
  assign sw.running   = (state_q == S_RUN);
  assign sw.cnt_reset = reset || (state_q == S_IDLE);

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, 5000000, clk cycles per tenth-second tick; legal range 2..2^24; 5000000 gives 10 Hz from 50 MHz.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 start_stop  input  1  raw asynchronous start/stop pushbutton level, active-high.
REQ-005 clear  input  1  raw asynchronous clear pushbutton level, active-high.
REQ-006 go  output  1  one-cycle enable pulse per tenth-second while running; drives the counter block's go.
REQ-007 cnt_reset  output  1  active-high clear to the counter block; drives the counter block's reset.
REQ-008 running  output  1  high while the FSM is in RUN.
REQ-009 lap_hold  output  1  display-freeze request to the display stage (see Configuration).

Function
REQ-010 Each button SHALL pass through a two-flop synchronizer and a previous-value flop; a press event is sync2=1 and prev=0.
REQ-011 A button high at sampling edge k SHALL change FSM state at edge k+2; a held button SHALL produce exactly one event.
REQ-012 The FSM SHALL have states IDLE, RUN and PAUSED, binary encoded in 2 bits; encoding 2'b11 SHALL return to IDLE on the next edge.
REQ-013 IDLE + start_stop event SHALL go to RUN; RUN + start_stop event SHALL go to PAUSED; PAUSED + start_stop event SHALL go to RUN.
REQ-014 PAUSED + clear event SHALL go to IDLE; a clear event in IDLE SHALL have no effect.
REQ-015 A clear event in RUN SHALL not change state (lap behaviour per REQ-026).
REQ-016 When start_stop and clear events occur in the same cycle, start_stop SHALL take priority and clear SHALL be discarded.
REQ-017 Prescaler: ceil(log2(TICK_DIV))-bit counter; counts 0..TICK_DIV-1 and wraps to 0, only in RUN.
REQ-018 The prescaler SHALL hold its value in PAUSED, so a resume preserves the partial tenth.
REQ-019 The prescaler SHALL be 0 in IDLE and on every IDLE-to-RUN transition.
REQ-020 go SHALL be high for exactly one cycle when state is RUN and prescaler equals TICK_DIV-1; otherwise go is 0.
REQ-021 The first go after IDLE-to-RUN SHALL be TICK_DIV cycles after the transition edge.
REQ-022 cnt_reset SHALL equal reset OR (state==IDLE), so the counter is held clear throughout IDLE.
REQ-023 running SHALL be decoded from the registered state only, with no combinational path from buttons.

Reset
REQ-024 While reset is high at an edge: state=IDLE, prescaler=0, synchronizer and prev flops=0, lap_hold=0.
REQ-025 After reset: go=0, running=0, cnt_reset=1; reset mid-RUN SHALL abort to IDLE on that same edge with no further go pulse.

Configuration
REQ-026 With STOPWATCH_LAP_EN defined: a clear event in RUN toggles lap_hold; in PAUSED with lap_hold=1, clear clears lap_hold and stays PAUSED.
REQ-027 With STOPWATCH_LAP_EN defined: lap_hold SHALL be forced to 0 on entry to IDLE, and go continues independent of lap_hold.
REQ-028 Without STOPWATCH_LAP_EN: lap_hold SHALL be tied 0 and the port SHALL still exist; clear in RUN is ignored; clear in PAUSED goes to IDLE.

Verification (bench TICK_DIV=4)
REQ-029 Reset 2 cycles, then idle 10 cycles -> go=0, running=0, cnt_reset=1 throughout.
REQ-030 start_stop pulse at edge k -> running=1 from edge k+2; go pulses at k+6, k+10, k+14, each 1 cycle wide.
REQ-031 In RUN, start_stop after prescaler reaches 2; resume 20 cycles later -> no go during PAUSED; next go 2 cycles after resume.
REQ-032 In PAUSED, start_stop and clear pressed in the same cycle -> state RUN, cnt_reset stays 0; then start_stop, then clear -> IDLE, cnt_reset=1.
REQ-033 start_stop held high 50 cycles from IDLE -> exactly one transition, to RUN; reset asserted mid-RUN -> IDLE next edge, go=0.
REQ-034 STOPWATCH_LAP_EN defined: two clear events in RUN -> lap_hold 1 then 0, go cadence unchanged; undefined: lap_hold always 0.
